// File: rtl/t8051_bus_pkg.sv
// rtl/t8051_bus_pkg.sv - shared types and constants for the 8051 external bus responder
package t8051_bus_pkg;

  localparam int SYNC_STAGES_DEF = 2;
  localparam int MEM_LAT_MAX_DEF = 4;
  localparam int BUS_W           = 20;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_CMD,
    ST_RD_REQ,
    ST_RD_DRIVE,
    ST_WR_DATA,
    ST_WR_REQ
  } state_t;

  typedef struct packed {
    logic       ale;
    logic       psen_n;
    logic       rd_n;
    logic       wr_n;
    logic [7:0] p0;
    logic [7:0] p2;
  } bus_t;

  // Quiescent bus: no latch enable, all strobes released, address/data low.
  localparam bus_t BUS_IDLE = '{ale: 1'b0, psen_n: 1'b1, rd_n: 1'b1, wr_n: 1'b1,
                                p0: 8'h00, p2: 8'h00};

endpackage

// File: rtl/bus_sync.sv
// rtl/bus_sync.sv - multi-stage synchronizer for a whole bus group, resets to a given idle value
module bus_sync #(
  parameter int               WIDTH = 8,
  parameter int               DEPTH = 2,
  parameter logic [WIDTH-1:0] IDLE  = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stage [DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) stage[i] <= IDLE;
    end else begin
      stage[0] <= d;
      for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
    end
  end

  assign q = stage[DEPTH-1];

endmodule

// File: rtl/ext_bus_responder.sv
// rtl/ext_bus_responder.sv - 8051 external code/xdata bus responder bridging to a request/ack memory port
module ext_bus_responder
  import t8051_bus_pkg::*;
#(
  parameter int SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int MEM_LAT_MAX = MEM_LAT_MAX_DEF
) (
  input  logic        xtal2,
  input  logic        rst,
  input  logic        ale,
  input  logic        psen_n,
  input  logic        rd_n,
  input  logic        wr_n,
  input  logic [7:0]  p0_in,
  input  logic [7:0]  p2_in,
  output logic [7:0]  p0_out,
  output logic        p0_oe,
  output logic        mem_req,
  output logic        mem_we,
  output logic        mem_code,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_wdata,
  input  logic [7:0]  mem_rdata,
  input  logic        mem_ack,
  output logic        late_err
);

  localparam int               CNT_W     = $clog2(MEM_LAT_MAX + 2) + 1;
  localparam logic [CNT_W-1:0] LAT_LIMIT = CNT_W'(MEM_LAT_MAX + 1);

  bus_t             bus_raw;
  bus_t             bus_s;
  state_t           state;
  state_t           state_nx;
  logic             ale_q;
  logic             wr_n_q;
  logic             ale_rise;
  logic             ale_fall;
  logic             wr_rise;
  logic             rd_strobe_low;
  logic             in_req;
  logic             lat_over;
  logic             rd_fault;
  logic             rd_abort;
  logic [CNT_W-1:0] lat_cnt;

  assign bus_raw = {ale, psen_n, rd_n, wr_n, p0_in, p2_in};

  bus_sync #(
    .WIDTH (BUS_W),
    .DEPTH (SYNC_STAGES),
    .IDLE  (BUS_IDLE)
  ) u_bus_sync (
    .clk (xtal2),
    .rst (rst),
    .d   (bus_raw),
    .q   (bus_s)
  );

  always_ff @(posedge xtal2) begin
    if (rst) begin
      ale_q  <= 1'b0;
      wr_n_q <= 1'b1;
    end else begin
      ale_q  <= bus_s.ale;
      wr_n_q <= bus_s.wr_n;
    end
  end

  assign ale_rise      = bus_s.ale & ~ale_q;
  assign ale_fall      = ~bus_s.ale & ale_q;
  assign wr_rise       = bus_s.wr_n & ~wr_n_q;
  assign rd_strobe_low = mem_code ? ~bus_s.psen_n : ~bus_s.rd_n;
  assign in_req        = (state == ST_RD_REQ) || (state == ST_WR_REQ);
  assign lat_over      = in_req && !mem_ack && (lat_cnt == LAT_LIMIT);
  // Any of these means the initiator is no longer waiting for this read byte.
  assign rd_fault      = (state == ST_RD_REQ) && (!rd_strobe_low || ale_rise || lat_over);

  always_ff @(posedge xtal2) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:     if (bus_s.ale) state_nx = ST_ADDR;
      ST_ADDR:     if (ale_fall) state_nx = ST_CMD;
      ST_CMD: begin
        if (!bus_s.psen_n || !bus_s.rd_n) state_nx = ST_RD_REQ;
        else if (!bus_s.wr_n)             state_nx = ST_WR_DATA;
        else if (bus_s.ale)               state_nx = ST_ADDR;
      end
      ST_RD_REQ:   if (mem_ack) state_nx = (rd_abort || rd_fault) ? ST_IDLE : ST_RD_DRIVE;
      ST_RD_DRIVE: if (!rd_strobe_low || bus_s.ale) state_nx = ST_IDLE;
      ST_WR_DATA:  if (wr_rise) state_nx = ST_WR_REQ;
      ST_WR_REQ:   if (mem_ack) state_nx = ST_IDLE;
      default:     state_nx = ST_IDLE;
    endcase
  end

  always_comb begin
    mem_req = in_req;
    mem_we  = (state == ST_WR_REQ);
    p0_oe   = (state == ST_RD_DRIVE) && rd_strobe_low && !bus_s.ale && bus_s.wr_n;
  end

  always_ff @(posedge xtal2) begin
    if (rst) begin
      p0_out    <= 8'h00;
      mem_code  <= 1'b0;
      mem_addr  <= 16'h0000;
      mem_wdata <= 8'h00;
      late_err  <= 1'b0;
      rd_abort  <= 1'b0;
      lat_cnt   <= '0;
    end else begin
      if (state == ST_ADDR && ale_fall) mem_addr <= {bus_s.p2, bus_s.p0};
      if (state == ST_CMD && (!bus_s.psen_n || !bus_s.rd_n)) mem_code <= ~bus_s.psen_n;
      if (state == ST_WR_DATA && wr_rise) mem_wdata <= bus_s.p0;
      if (state == ST_RD_REQ && mem_ack && !(rd_abort || rd_fault)) p0_out <= mem_rdata;

      if (state != ST_RD_REQ) rd_abort <= 1'b0;
      else if (rd_fault)      rd_abort <= 1'b1;

      if (!in_req)                  lat_cnt <= '0;
      else if (lat_cnt != LAT_LIMIT) lat_cnt <= lat_cnt + CNT_W'(1);

      if (rd_fault || lat_over || (in_req && ale_rise)) late_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ext_bus_responder.sv
// tb/tb_ext_bus_responder.sv - randomized self-checking bench for ext_bus_responder
module tb_ext_bus_responder;

  localparam int MEM_LAT_MAX = 4;

  logic        xtal2 = 1'b0;
  logic        rst, ale, psen_n, rd_n, wr_n, mem_ack;
  logic [7:0]  p0_in, p2_in, mem_rdata;
  logic [7:0]  p0_out, mem_wdata;
  logic        p0_oe, mem_req, mem_we, mem_code, late_err;
  logic [15:0] mem_addr;

  int n_cmp = 0;
  int n_bad = 0;
  int req_count = 0;
  bit req_prev = 1'b0;
  bit oe_seen = 1'b0;
  bit exp_late = 1'b0;

  ext_bus_responder #(.SYNC_STAGES(2), .MEM_LAT_MAX(MEM_LAT_MAX)) dut (
    .xtal2(xtal2), .rst(rst), .ale(ale), .psen_n(psen_n), .rd_n(rd_n), .wr_n(wr_n),
    .p0_in(p0_in), .p2_in(p2_in), .p0_out(p0_out), .p0_oe(p0_oe), .mem_req(mem_req),
    .mem_we(mem_we), .mem_code(mem_code), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .late_err(late_err)
  );

  always #5 xtal2 = ~xtal2;

  always @(negedge xtal2) begin
    if (mem_req && !req_prev) req_count++;
    req_prev = mem_req;
    if (p0_oe) oe_seen = 1'b1;
  end

  task automatic bus_idle();
    ale = 1'b0; psen_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1;
    p0_in = 8'h00; p2_in = 8'h00; mem_ack = 1'b0; mem_rdata = 8'h00;
  endtask

  task automatic do_reset();
    @(negedge xtal2);
    bus_idle();
    rst = 1'b1;
    repeat (2) @(negedge xtal2);
    rst = 1'b0;
    exp_late = 1'b0;
    @(negedge xtal2);
  endtask

  task automatic addr_phase(input logic [15:0] a);
    @(negedge xtal2);
    ale = 1'b1; p2_in = a[15:8]; p0_in = a[7:0];
    repeat (2) @(negedge xtal2);
    ale = 1'b0;
    repeat (2) @(negedge xtal2);
    p0_in = 8'($urandom);
  endtask

  task automatic wait_req(output bit got);
    got = 1'b0;
    for (int i = 0; i < 24; i++) begin
      @(negedge xtal2);
      if (mem_req) begin got = 1'b1; break; end
    end
  endtask

  task automatic do_read(input logic [15:0] a, input bit use_psen, input bit use_rd,
                         input int dly, input bit early, input logic [7:0] rdat,
                         output bit got, output logic [15:0] o_addr, output logic o_code,
                         output logic o_we, output logic o_oe_ack, output logic [7:0] o_p0,
                         output bit o_dropped);
    addr_phase(a);
    psen_n = !use_psen; rd_n = !use_rd;
    wait_req(got);
    o_addr = mem_addr; o_code = mem_code; o_we = mem_we;
    o_oe_ack = 1'b0; o_p0 = p0_out; o_dropped = 1'b0;
    if (got) begin
      if (early) begin psen_n = 1'b1; rd_n = 1'b1; end
      repeat (dly) @(negedge xtal2);
      mem_ack = 1'b1; mem_rdata = rdat;
      @(negedge xtal2);
      mem_ack = 1'b0;
      o_oe_ack = p0_oe; o_p0 = p0_out;
    end
    repeat (2) @(negedge xtal2);
    psen_n = 1'b1; rd_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge xtal2);
      if (!p0_oe) begin o_dropped = 1'b1; break; end
    end
    repeat (2) @(negedge xtal2);
  endtask

  task automatic do_write(input logic [15:0] a, input logic [7:0] data, input int dly,
                          output bit got, output logic [15:0] o_addr, output logic o_we,
                          output logic [7:0] o_wdata, output logic o_req_after);
    addr_phase(a);
    wr_n = 1'b0; p0_in = data;
    repeat (3) @(negedge xtal2);
    wr_n = 1'b1;
    wait_req(got);
    o_addr = mem_addr; o_we = mem_we; o_wdata = mem_wdata; o_req_after = mem_req;
    if (got) begin
      repeat (dly) @(negedge xtal2);
      mem_ack = 1'b1;
      @(negedge xtal2);
      mem_ack = 1'b0;
      o_req_after = mem_req;
    end
    p0_in = 8'($urandom);
    repeat (3) @(negedge xtal2);
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++; if ({p0_out, p0_oe, mem_req, mem_we, mem_code, mem_addr, mem_wdata, late_err} !== 37'd0) begin
      n_bad++; $display("FAIL reset_outputs got p0_out=%h oe=%b req=%b we=%b code=%b addr=%h wdata=%h late=%b want all zero",
                        p0_out, p0_oe, mem_req, mem_we, mem_code, mem_addr, mem_wdata, late_err); end
  endtask

  task automatic test_code_read();
    bit got, dropped; logic [15:0] ad; logic cd, we, oe; logic [7:0] p0v; int c0;
    c0 = req_count; oe_seen = 1'b0;
    do_read(16'h1234, 1'b1, 1'b0, 2, 1'b0, 8'hA5, got, ad, cd, we, oe, p0v, dropped);
    n_cmp++; if (got !== 1'b1) begin n_bad++; $display("FAIL code_read_req got=%b want=1", got); end
    n_cmp++; if (ad !== 16'h1234) begin n_bad++; $display("FAIL code_read_addr got=%h want=1234", ad); end
    n_cmp++; if ({cd, we} !== 2'b10) begin n_bad++; $display("FAIL code_read_code_we got=%b%b want=10", cd, we); end
    n_cmp++; if ({oe, p0v} !== {1'b1, 8'hA5}) begin n_bad++; $display("FAIL code_read_drive got oe=%b p0=%h want oe=1 p0=a5", oe, p0v); end
    n_cmp++; if (dropped !== 1'b1) begin n_bad++; $display("FAIL code_read_oe_release got=%b want=1", dropped); end
    n_cmp++; if (req_count - c0 !== 1) begin n_bad++; $display("FAIL code_read_req_count got=%0d want=1", req_count - c0); end
    n_cmp++; if (late_err !== 1'b0) begin n_bad++; $display("FAIL code_read_late got=%b want=0", late_err); end
  endtask

  task automatic test_write();
    bit got; logic [15:0] ad; logic we, rq; logic [7:0] wd; int c0;
    c0 = req_count; oe_seen = 1'b0;
    do_write(16'h8001, 8'h5A, 1, got, ad, we, wd, rq);
    n_cmp++; if (got !== 1'b1) begin n_bad++; $display("FAIL write_req got=%b want=1", got); end
    n_cmp++; if ({ad, we, wd} !== {16'h8001, 1'b1, 8'h5A}) begin n_bad++;
      $display("FAIL write_fields got addr=%h we=%b wdata=%h want addr=8001 we=1 wdata=5a", ad, we, wd); end
    n_cmp++; if (rq !== 1'b0) begin n_bad++; $display("FAIL write_req_after_ack got=%b want=0", rq); end
    n_cmp++; if (oe_seen !== 1'b0) begin n_bad++; $display("FAIL write_oe_seen got=%b want=0", oe_seen); end
    n_cmp++; if (req_count - c0 !== 1) begin n_bad++; $display("FAIL write_req_count got=%0d want=1", req_count - c0); end
  endtask

  task automatic test_priority();
    bit got, dropped; logic [15:0] ad; logic cd, we, oe; logic [7:0] p0v; int c0;
    c0 = req_count;
    do_read(16'h2B7C, 1'b1, 1'b1, 1, 1'b0, 8'h3C, got, ad, cd, we, oe, p0v, dropped);
    n_cmp++; if ({got, cd, ad} !== {1'b1, 1'b1, 16'h2B7C}) begin n_bad++;
      $display("FAIL priority_code got req=%b code=%b addr=%h want req=1 code=1 addr=2b7c", got, cd, ad); end
    n_cmp++; if (req_count - c0 !== 1) begin n_bad++; $display("FAIL priority_req_count got=%0d want=1", req_count - c0); end
  endtask

  task automatic test_double_ale();
    bit got, dropped; logic [15:0] ad; logic cd, we, oe; logic [7:0] p0v; int c0;
    c0 = req_count;
    addr_phase(16'h4455);
    repeat (2) @(negedge xtal2);
    do_read(16'h6677, 1'b0, 1'b1, 0, 1'b0, 8'h96, got, ad, cd, we, oe, p0v, dropped);
    n_cmp++; if ({ad, cd, p0v} !== {16'h6677, 1'b0, 8'h96}) begin n_bad++;
      $display("FAIL double_ale got addr=%h code=%b p0=%h want addr=6677 code=0 p0=96", ad, cd, p0v); end
    n_cmp++; if (req_count - c0 !== 1) begin n_bad++; $display("FAIL double_ale_req_count got=%0d want=1", req_count - c0); end
  endtask

  task automatic test_random_traffic();
    bit got, dropped; logic [15:0] ad, a; logic cd, we, oe, rq; logic [7:0] p0v, wd, d;
    int kind, dly, c0;
    for (int it = 0; it < 12; it++) begin
      kind = $urandom_range(0, 2); a = 16'($urandom); d = 8'($urandom); dly = $urandom_range(0, MEM_LAT_MAX);
      c0 = req_count; oe_seen = 1'b0;
      if (kind < 2) begin
        do_read(a, kind == 0, kind == 1, dly, 1'b0, d, got, ad, cd, we, oe, p0v, dropped);
        n_cmp++; if ({got, ad, cd, we, oe, p0v, dropped} !== {1'b1, a, kind == 0, 1'b0, 1'b1, d, 1'b1}) begin n_bad++;
          $display("FAIL rand_read[%0d] got req=%b addr=%h code=%b we=%b oe=%b p0=%h rel=%b want 1 %h %b 0 1 %h 1",
                   it, got, ad, cd, we, oe, p0v, dropped, a, kind == 0, d); end
      end else begin
        do_write(a, d, dly, got, ad, we, wd, rq);
        n_cmp++; if ({got, ad, we, wd, rq, oe_seen} !== {1'b1, a, 1'b1, d, 1'b0, 1'b0}) begin n_bad++;
          $display("FAIL rand_write[%0d] got req=%b addr=%h we=%b wdata=%h req_after=%b oe=%b want 1 %h 1 %h 0 0",
                   it, got, ad, we, wd, rq, oe_seen, a, d); end
      end
      n_cmp++; if (req_count - c0 !== 1) begin n_bad++; $display("FAIL rand_req_count[%0d] got=%0d want=1", it, req_count - c0); end
      n_cmp++; if (late_err !== exp_late) begin n_bad++; $display("FAIL rand_late[%0d] got=%b want=%b", it, late_err, exp_late); end
    end
  endtask

  task automatic test_late();
    bit got, dropped; logic [15:0] ad; logic cd, we, oe, rq; logic [7:0] p0v, wd; int c0;
    c0 = req_count; oe_seen = 1'b0;
    do_read(16'h0200, 1'b1, 1'b0, 4, 1'b1, 8'h77, got, ad, cd, we, oe, p0v, dropped);
    exp_late = 1'b1;
    n_cmp++; if ({got, oe_seen, late_err} !== {1'b1, 1'b0, exp_late}) begin n_bad++;
      $display("FAIL late_early_release got req=%b oe=%b late=%b want req=1 oe=0 late=1", got, oe_seen, late_err); end
    n_cmp++; if (req_count - c0 !== 1) begin n_bad++; $display("FAIL late_early_req_count got=%0d want=1", req_count - c0); end
    do_write(16'h0404, 8'h11, 0, got, ad, we, wd, rq);
    n_cmp++; if (late_err !== exp_late) begin n_bad++; $display("FAIL late_sticky got=%b want=%b", late_err, exp_late); end
    do_reset();
    n_cmp++; if (late_err !== exp_late) begin n_bad++; $display("FAIL late_cleared_by_rst got=%b want=%b", late_err, exp_late); end
    for (int dly = MEM_LAT_MAX + 2; dly <= MEM_LAT_MAX + 4; dly += 2) begin
      oe_seen = 1'b0;
      do_read(16'h0300 + 16'(dly), 1'b0, 1'b1, dly, 1'b0, 8'h88, got, ad, cd, we, oe, p0v, dropped);
      exp_late = exp_late | (dly > MEM_LAT_MAX);
      n_cmp++; if ({got, oe_seen, late_err} !== {1'b1, 1'b0, exp_late}) begin n_bad++;
        $display("FAIL late_slow_ack[%0d] got req=%b oe=%b late=%b want req=1 oe=0 late=%b", dly, got, oe_seen, late_err, exp_late); end
      do_reset();
    end
  endtask

  task automatic test_reset_mid_request();
    bit got; bit req_after_rst = 1'b0; int c0;
    addr_phase(16'h5150);
    psen_n = 1'b0;
    wait_req(got);
    n_cmp++; if (got !== 1'b1) begin n_bad++; $display("FAIL rst_mid_req_start got=%b want=1", got); end
    rst = 1'b1;
    @(negedge xtal2);
    n_cmp++; if ({mem_req, p0_oe, mem_code, mem_addr, late_err} !== 20'd0) begin n_bad++;
      $display("FAIL rst_mid_req_drop got req=%b oe=%b code=%b addr=%h late=%b want all zero", mem_req, p0_oe, mem_code, mem_addr, late_err); end
    bus_idle();
    @(negedge xtal2);
    rst = 1'b0;
    exp_late = 1'b0;
    c0 = req_count; oe_seen = 1'b0;
    @(negedge xtal2);
    mem_ack = 1'b1; mem_rdata = 8'hFF;
    @(negedge xtal2);
    mem_ack = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge xtal2);
      if (mem_req) req_after_rst = 1'b1;
    end
    n_cmp++; if ({req_after_rst, oe_seen, p0_out, late_err} !== 11'd0) begin n_bad++;
      $display("FAIL rst_stray_ack got req=%b oe=%b p0=%h late=%b want 0 0 00 0", req_after_rst, oe_seen, p0_out, late_err); end
    n_cmp++; if (req_count - c0 !== 0) begin n_bad++; $display("FAIL rst_stray_req_count got=%0d want=0", req_count - c0); end
  endtask

  initial begin
    bus_idle();
    rst = 1'b1;
    test_reset();
    test_code_read();
    test_write();
    test_priority();
    test_double_ale();
    test_random_traffic();
    test_late();
    test_reset_mid_request();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
